// File: rtl/histogram_pkg.sv
// Shared types and sizing for the pixel histogram stage and its downstream derivative stage.
package histogram_pkg;

    localparam int NUM_BINS    = 256;
    localparam int BIN_W       = 16;
    localparam int PIX_W       = 8;
    localparam int HIST_FLAT_W = NUM_BINS * BIN_W;

    typedef logic [BIN_W-1:0] bin_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } hist_state_t;

endpackage

// File: rtl/hist_bin_update.sv
// Next-value logic for one histogram bin: optional clear, then a saturating +1.
module hist_bin_update
    import histogram_pkg::*;
(
    input  bin_t i_bin,
    input  logic i_clear,
    input  logic i_inc,
    output bin_t o_bin,
    output logic o_sat
);

    bin_t base;

    always_comb begin
        base  = i_clear ? '0 : i_bin;
        o_bin = base;
        o_sat = 1'b0;
        if (i_inc) begin
            if (&base) begin
                o_sat = 1'b1;
            end else begin
                o_bin = base + 1'b1;
            end
        end
    end

endmodule

// File: rtl/histogram_accumulator.sv
// Streams 8-bit pixels into 256 saturating 16-bit bins and snapshots them at end of frame.
module histogram_accumulator
    import histogram_pkg::*;
#(
    parameter int TOP       = 1,
    parameter int PIX_CNT_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [PIX_W-1:0]       i_pixel,
    input  logic                   i_pixel_valid,
    input  logic                   i_sof,
    input  logic                   i_eof,
    output logic [HIST_FLAT_W-1:0] o_histogram_flat,
    output logic                   o_hist_valid,
    output logic [PIX_CNT_W-1:0]   o_pixel_count,
    output logic                   o_saturated,
    output logic                   o_frame_err,
    output logic                   o_busy
);

    // Waveform capture for standalone runs is left to the simulation harness.
    if (TOP != 0) begin : g_standalone
    end

    logic [PIX_W-1:0]       pix_q, pix_d;
    logic                   valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
    hist_state_t            state_q, state_d;
    logic [PIX_CNT_W-1:0]   count_q, count_d, snap_count_q, snap_count_d;
    logic                   sat_q, sat_d, snap_sat_q, snap_sat_d;
    logic                   hist_valid_q, hist_valid_d, frame_err_q, frame_err_d;
    logic [HIST_FLAT_W-1:0] snap_q, snap_d, next_flat;
    logic [NUM_BINS-1:0]    bin_sat;
    logic                   do_clear, do_inc, do_snap, any_sat;

    always_comb begin
        pix_d   = i_pixel;
        valid_d = i_pixel_valid;
        sof_d   = i_pixel_valid & i_sof;
        eof_d   = i_pixel_valid & i_eof;
    end

    // An sof pixel always starts a frame; an sof seen mid-frame restarts it.
    always_comb begin
        do_clear    = valid_q & sof_q;
        do_inc      = valid_q & (sof_q | (state_q == ACCUM));
        do_snap     = do_inc & eof_q;
        frame_err_d = valid_q & ((sof_q & (state_q == ACCUM)) |
                                 (eof_q & ~sof_q & (state_q == IDLE)));
        state_d = state_q;
        if (do_snap) begin
            state_d = IDLE;
        end else if (do_clear) begin
            state_d = ACCUM;
        end
    end

    // Bins live in flops rather than RAM because sof has to clear all of them in one cycle.
    for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
        bin_t bin_q, bin_d;

        hist_bin_update u_update (
            .i_bin   (bin_q),
            .i_clear (do_clear),
            .i_inc   (do_inc & (pix_q == PIX_W'(gi))),
            .o_bin   (bin_d),
            .o_sat   (bin_sat[gi])
        );

        assign next_flat[BIN_W*gi +: BIN_W] = bin_d;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                bin_q <= '0;
            end else begin
                bin_q <= bin_d;
            end
        end
    end

    assign any_sat = |bin_sat;

    always_comb begin
        count_d = count_q;
        if (do_clear) begin
            count_d = PIX_CNT_W'(1);
        end else if (do_inc && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
        sat_d        = (sat_q & ~do_clear) | any_sat;
        hist_valid_d = do_snap;
        snap_d       = do_snap ? next_flat : snap_q;
        snap_count_d = do_snap ? count_d   : snap_count_q;
        snap_sat_d   = do_snap ? sat_d     : snap_sat_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_q        <= '0;
            valid_q      <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            state_q      <= IDLE;
            count_q      <= '0;
            sat_q        <= 1'b0;
            hist_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            snap_q       <= '0;
            snap_count_q <= '0;
            snap_sat_q   <= 1'b0;
        end else begin
            pix_q        <= pix_d;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            state_q      <= state_d;
            count_q      <= count_d;
            sat_q        <= sat_d;
            hist_valid_q <= hist_valid_d;
            frame_err_q  <= frame_err_d;
            snap_q       <= snap_d;
            snap_count_q <= snap_count_d;
            snap_sat_q   <= snap_sat_d;
        end
    end

    assign o_histogram_flat = snap_q;
    assign o_hist_valid     = hist_valid_q;
    assign o_pixel_count    = snap_count_q;
    assign o_saturated      = snap_sat_q;
    assign o_frame_err      = frame_err_q;
    assign o_busy           = (state_q == ACCUM);

endmodule
